mem_port: RTL and testbench
===========================

Name: mem_port

Overview:
- CPU-side master for the unified 16-bit memory block. Drives its read, write, d_addr, i_addr and d_bus, and consumes i_bus.
- Gives the core two independent request channels:
  - a fully pipelined instruction-fetch channel;
  - a handshaked load/store channel, sequenced by an FSM.
- The FSM respects the memory's one-cycle synchronous read and its tri-state d_bus ownership rules.

Parameters:
- AW, 16, address width (d_addr, i_addr, f_addr, ls_addr).
- DW, 16, data width (d_bus, i_bus, all data ports).

Ports:
- clk  input  1  system clock; all state changes on posedge.
- rst  input  1  asynchronous, active-high reset.
- f_req  input  1  fetch request this cycle.
- f_addr  input  AW  fetch address.
- f_valid  output  1  f_data is valid this cycle.
- f_data  output  DW  fetched word.
- ls_req  input  1  load/store request; sampled only when ls_ready=1.
- ls_we  input  1  1 = store, 0 = load.
- ls_addr  input  AW  load/store address.
- ls_wdata  input  DW  store data.
- ls_ready  output  1  FSM idle; a request is accepted this cycle.
- ls_done  output  1  one-cycle completion pulse.
- ls_rdata  output  DW  load result; holds until the next load completes.
- i_addr  output  AW  to memory instruction address.
- i_bus  input  DW  from memory instruction data (registered in memory).
- mem_read  output  1  to memory read (enables memory's d_bus driver).
- mem_write  output  1  to memory write.
- d_addr  output  AW  to memory data address.
- d_bus  inout  DW  shared data bus.

Behaviour:
- Reset (async, immediate), all registers cleared:
  - state=IDLE;
  - mem_read=0, mem_write=0, d_addr=0;
  - d_bus released (high-Z);
  - ls_rdata=0, ls_done=0, f_valid=0.
  - ls_ready=1 once rst deasserts.
- Fetch channel (no FSM, latency 1, throughput 1 per cycle):
  - i_addr = f_addr, combinationally.
  - f_valid is f_req registered.
  - f_data = i_bus, combinationally. It is meaningful only while f_valid=1.
  - Unaffected by load/store activity.
- Load/store FSM: states IDLE, WRITE, RADDR, RDATA, DONE.
  - mem_read, mem_write and d_addr are registers, loaded on the transition into a state, so they are glitch-free.
- IDLE:
  - ls_ready=1.
  - On ls_req: latch ls_addr into d_addr, and ls_wdata into an internal wbuf.
  - If ls_we=1: go to WRITE, set mem_write=1. Otherwise go to RADDR.
  - Without ls_req: stay in IDLE.
- WRITE:
  - mem_write=1; d_bus driven with wbuf.
  - Memory commits at the closing edge.
  - Next state: DONE, with mem_write cleared.
- RADDR:
  - d_addr stable, mem_read=0, d_bus not driven; memory captures mem[d_addr] at the closing edge.
  - Next state: RDATA, with mem_read set.
- RDATA:
  - mem_read=1, memory drives d_bus.
  - At the closing edge, ls_rdata <= d_bus.
  - Next state: DONE, with mem_read cleared.
- DONE:
  - ls_done=1 for exactly this cycle; ls_ready=0.
  - Next state: IDLE.
- Latency from the accept edge to ls_done high:
  - store: 2 cycles (WRITE, DONE);
  - load: 3 cycles (RADDR, RDATA, DONE).
- Max rate: one store per 3 cycles, one load per 4 cycles.
- Bus ownership invariants:
  - d_bus is driven by mem_port only in WRITE.
  - mem_read=1 only in RDATA.
  - mem_read and mem_write are never both 1.
  - DONE/IDLE act as the turnaround between a write drive and a subsequent read.
- Requests while ls_ready=0 are ignored; no queuing. The requester holds ls_req until it observes ls_ready.
- Same-address fetch during WRITE: i_bus returns the pre-write value (memory is read-before-write). The new value is visible to fetches issued after the write edge.
- Reset mid-operation (in WRITE/RDATA):
  - outputs clear immediately; d_bus is released;
  - no write commits at any edge where rst=1;
  - no ls_done is produced for the aborted request.
- Address and data are passed unmodified; no width arithmetic. Out-of-range addresses are the memory's concern.

Test Plan:
- Reset: hold rst with ls_req=1, ls_we=1 -> mem_write=0, d_bus=Z, ls_ready=1 after release, ls_rdata=0.
- Store then load: store 0xAAAA @0x000F, then load @0x000F -> store ls_done 2 cycles after accept; load ls_done 3 cycles after accept with ls_rdata=0xAAAA.
- Back-to-back fetch: f_req=1 on addresses 0,1,2,3 in consecutive cycles, memory preloaded -> f_valid=1 for 4 cycles with words in order, one cycle after each request.
- Fetch/store collision: fetch @0x0005 issued the same cycle WRITE of 0x1234 @0x0005 is active -> f_data = old word; refetch the next cycle -> 0x1234.
- Request while busy: pulse ls_req during RADDR with a different address -> ignored; only one ls_done; d_addr unchanged. Assertion: never mem_read && mem_write; never mem_read while mem_port drives d_bus.
- Reset mid-write: assert rst during WRITE of 0x5555 @0x0010 -> location keeps its old value; no ls_done; FSM returns to IDLE.

Source files
------------

// File: rtl/mem_port.sv
// CPU-side master for the unified 16-bit memory: a pipelined fetch channel plus
// a handshaked load/store channel sequenced by a small FSM.
//
// state | meaning
// IDLE  | ls_ready=1; accept a request, latch address and store data
// WRITE | mem_write=1, drive d_bus with the store data; memory commits at edge
// RADDR | address presented with bus released; memory captures mem[d_addr]
// RDATA | mem_read=1, memory drives d_bus; capture into ls_rdata at edge
// DONE  | ls_done pulse; also the bus turnaround before the next request
module mem_port #(
    parameter int AW = 16,
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          f_req,
    input  logic [AW-1:0] f_addr,
    output logic          f_valid,
    output logic [DW-1:0] f_data,
    input  logic          ls_req,
    input  logic          ls_we,
    input  logic [AW-1:0] ls_addr,
    input  logic [DW-1:0] ls_wdata,
    output logic          ls_ready,
    output logic          ls_done,
    output logic [DW-1:0] ls_rdata,
    output logic [AW-1:0] i_addr,
    input  logic [DW-1:0] i_bus,
    output logic          mem_read,
    output logic          mem_write,
    output logic [AW-1:0] d_addr,
    inout  wire  [DW-1:0] d_bus
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WRITE = 3'd1,
        RADDR = 3'd2,
        RDATA = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic          mem_read_q, mem_read_d;
    logic          mem_write_q, mem_write_d;
    logic [AW-1:0] d_addr_q, d_addr_d;
    logic [DW-1:0] wbuf_q, wbuf_d;
    logic [DW-1:0] ls_rdata_q, ls_rdata_d;
    logic          ls_done_q, ls_done_d;
    logic          f_valid_q, f_valid_d;

    always_comb begin
        state_d     = state_q;
        mem_read_d  = mem_read_q;
        mem_write_d = mem_write_q;
        d_addr_d    = d_addr_q;
        wbuf_d      = wbuf_q;
        ls_rdata_d  = ls_rdata_q;
        ls_done_d   = 1'b0;
        f_valid_d   = f_req;
        case (state_q)
            IDLE: begin
                if (ls_req) begin
                    d_addr_d = ls_addr;
                    wbuf_d   = ls_wdata;
                    if (ls_we) begin
                        state_d     = WRITE;
                        mem_write_d = 1'b1;
                    end else begin
                        state_d = RADDR;
                    end
                end
            end
            WRITE: begin
                state_d     = DONE;
                mem_write_d = 1'b0;
                ls_done_d   = 1'b1;
            end
            RADDR: begin
                state_d    = RDATA;
                mem_read_d = 1'b1;
            end
            RDATA: begin
                state_d    = DONE;
                mem_read_d = 1'b0;
                ls_rdata_d = d_bus;
                ls_done_d  = 1'b1;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d     = IDLE;
                mem_read_d  = 1'b0;
                mem_write_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            d_addr_q    <= '0;
            wbuf_q      <= '0;
            ls_rdata_q  <= '0;
            ls_done_q   <= 1'b0;
            f_valid_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
            d_addr_q    <= d_addr_d;
            wbuf_q      <= wbuf_d;
            ls_rdata_q  <= ls_rdata_d;
            ls_done_q   <= ls_done_d;
            f_valid_q   <= f_valid_d;
        end
    end

    // mem_write_q is high exactly in WRITE, so it doubles as the bus-drive enable
    assign d_bus     = mem_write_q ? wbuf_q : {DW{1'bz}};

    assign i_addr    = f_addr;
    assign f_data    = i_bus;
    assign f_valid   = f_valid_q;
    assign ls_ready  = (state_q == IDLE);
    assign ls_done   = ls_done_q;
    assign ls_rdata  = ls_rdata_q;
    assign mem_read  = mem_read_q;
    assign mem_write = mem_write_q;
    assign d_addr    = d_addr_q;

endmodule

// File: tb/tb_mem_port.sv
// Directed bench for mem_port with a behavioural read-before-write memory and
// scoreboard queues for fetch words and load/store completions.
module tb_mem_port;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        f_req = 1'b0;
    logic [15:0] f_addr = '0;
    logic        f_valid;
    logic [15:0] f_data;
    logic        ls_req = 1'b0;
    logic        ls_we = 1'b0;
    logic [15:0] ls_addr = '0;
    logic [15:0] ls_wdata = '0;
    logic        ls_ready;
    logic        ls_done;
    logic [15:0] ls_rdata;
    logic [15:0] i_addr;
    logic [15:0] i_bus;
    logic        mem_read;
    logic        mem_write;
    logic [15:0] d_addr;
    wire  [15:0] d_bus;

    int errors = 0;
    int checks = 0;
    int done_cnt = 0;
    int fv_cnt = 0;
    logic [15:0] fetch_q[$];
    logic [15:0] done_q[$];
    logic [15:0] last_rd = '0;

    logic        load_mem = 1'b1;
    logic [15:0] mem [0:255];
    logic [15:0] rd_q;
    logic [15:0] ib_q;

    always #5 clk = ~clk;

    mem_port #(.AW(16), .DW(16)) dut (
        .clk(clk), .rst(rst),
        .f_req(f_req), .f_addr(f_addr), .f_valid(f_valid), .f_data(f_data),
        .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
        .ls_ready(ls_ready), .ls_done(ls_done), .ls_rdata(ls_rdata),
        .i_addr(i_addr), .i_bus(i_bus),
        .mem_read(mem_read), .mem_write(mem_write), .d_addr(d_addr), .d_bus(d_bus)
    );

    // External memory: one-cycle registered reads on both ports, read-before-write.
    always @(posedge clk) begin
        if (load_mem) begin
            for (int i = 0; i < 256; i++) mem[i] <= 16'hC000 + 16'(i);
        end else if (mem_write) begin
            mem[d_addr[7:0]] <= d_bus;
        end
        rd_q <= mem[d_addr[7:0]];
        ib_q <= mem[i_addr[7:0]];
    end
    assign i_bus = ib_q;
    assign d_bus = mem_read ? rd_q : 16'hzzzz;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard side: pop on every DUT completion and bus-rule checks.
    always @(negedge clk) begin
        if (!rst) begin
            chk("rw_exclusive", {31'b0, mem_read & mem_write}, 32'd0);
            if (f_valid) begin
                fv_cnt++;
                if (fetch_q.size() == 0) chk("fetch_unexpected", 32'd1, 32'd0);
                else chk("fetch_data", {16'b0, f_data}, {16'b0, fetch_q.pop_front()});
            end
            if (ls_done) begin
                done_cnt++;
                if (done_q.size() == 0) chk("ls_done_unexpected", 32'd1, 32'd0);
                else chk("ls_rdata_at_done", {16'b0, ls_rdata}, {16'b0, done_q.pop_front()});
            end
        end
    end

    task automatic do_req(input logic we, input logic [15:0] addr, input logic [15:0] wd,
                          input logic [15:0] exp_rd, input int exp_lat);
        int n;
        ls_req = 1'b1; ls_we = we; ls_addr = addr; ls_wdata = wd;
        chk("ready_before_accept", {31'b0, ls_ready}, 32'd1);
        done_q.push_back(exp_rd);
        tick();
        ls_req = 1'b0;
        n = 1;
        if (we) begin
            chk("write_strobe", {31'b0, mem_write}, 32'd1);
            chk("write_bus", {16'b0, d_bus}, {16'b0, wd});
        end
        while (!ls_done && n < 10) begin
            tick();
            n++;
        end
        chk(we ? "store_latency" : "load_latency", 32'(n), 32'(exp_lat));
        chk("done_not_ready", {31'b0, ls_ready}, 32'd0);
        tick();
    endtask

    initial begin
        int d0;
        // Reset held with a pending store request
        ls_req = 1'b1; ls_we = 1'b1; ls_addr = 16'h0020; ls_wdata = 16'hDEAD;
        repeat (3) tick();
        load_mem = 1'b0;
        tick();
        chk("rst_mem_write", {31'b0, mem_write}, 32'd0);
        chk("rst_mem_read", {31'b0, mem_read}, 32'd0);
        chk("rst_d_addr", {16'b0, d_addr}, 32'd0);
        chk("rst_ls_rdata", {16'b0, ls_rdata}, 32'd0);
        chk("rst_ls_done", {31'b0, ls_done}, 32'd0);
        chk("rst_f_valid", {31'b0, f_valid}, 32'd0);
        chk("rst_no_commit", {16'b0, mem[8'h20]}, 32'hC020);
        ls_req = 1'b0;
        rst = 1'b0;
        #1;
        chk("ready_after_rst", {31'b0, ls_ready}, 32'd1);
        tick();

        // Store then load
        do_req(1'b1, 16'h000F, 16'hAAAA, last_rd, 2);
        chk("store_committed", {16'b0, mem[8'h0F]}, 32'hAAAA);
        last_rd = 16'hAAAA;
        do_req(1'b0, 16'h000F, 16'h0000, last_rd, 3);
        chk("load_hold", {16'b0, ls_rdata}, 32'hAAAA);

        // Back-to-back fetch
        d0 = fv_cnt;
        for (int i = 0; i < 4; i++) begin
            f_req = 1'b1; f_addr = 16'(i);
            fetch_q.push_back(16'hC000 + 16'(i));
            tick();
            chk("fetch_valid_stream", {31'b0, f_valid}, 32'd1);
        end
        f_req = 1'b0;
        tick();
        chk("fetch_count", 32'(fv_cnt - d0), 32'd4);
        chk("fetch_idle", {31'b0, f_valid}, 32'd0);

        // Fetch/store collision on 0x0005
        ls_req = 1'b1; ls_we = 1'b1; ls_addr = 16'h0005; ls_wdata = 16'h1234;
        done_q.push_back(last_rd);
        tick();
        ls_req = 1'b0;
        chk("collide_in_write", {31'b0, mem_write}, 32'd1);
        f_req = 1'b1; f_addr = 16'h0005;
        fetch_q.push_back(16'hC005);
        tick();
        fetch_q.push_back(16'h1234);
        tick();
        f_req = 1'b0;
        tick();
        chk("collide_fetch_drained", 32'(fetch_q.size()), 32'd0);

        // Request while busy during RADDR
        d0 = done_cnt;
        ls_req = 1'b1; ls_we = 1'b0; ls_addr = 16'h0005;
        done_q.push_back(16'h1234);
        tick();
        ls_addr = 16'h0030;
        tick();
        ls_req = 1'b0;
        chk("busy_rdata_read", {31'b0, mem_read}, 32'd1);
        chk("busy_d_addr", {16'b0, d_addr}, 32'h0005);
        repeat (4) tick();
        chk("busy_one_done", 32'(done_cnt - d0), 32'd1);
        chk("busy_d_addr_hold", {16'b0, d_addr}, 32'h0005);
        chk("busy_rdata", {16'b0, ls_rdata}, 32'h1234);
        last_rd = 16'h1234;

        // Reset in the middle of a store
        d0 = done_cnt;
        ls_req = 1'b1; ls_we = 1'b1; ls_addr = 16'h0010; ls_wdata = 16'h5555;
        tick();
        ls_req = 1'b0;
        chk("midrst_in_write", {31'b0, mem_write}, 32'd1);
        rst = 1'b1;
        #1;
        chk("midrst_write_cleared", {31'b0, mem_write}, 32'd0);
        chk("midrst_rdata_cleared", {16'b0, ls_rdata}, 32'd0);
        tick();
        rst = 1'b0;
        repeat (3) tick();
        chk("midrst_mem_kept", {16'b0, mem[8'h10]}, 32'hC010);
        chk("midrst_no_done", 32'(done_cnt - d0), 32'd0);
        chk("midrst_idle", {31'b0, ls_ready}, 32'd1);
        last_rd = 16'h0000;

        do_req(1'b0, 16'h0010, 16'h0000, 16'hC010, 3);
        do_req(1'b0, 16'h000F, 16'h0000, 16'hAAAA, 3);

        repeat (2) tick();
        chk("scoreboard_fetch_empty", 32'(fetch_q.size()), 32'd0);
        chk("scoreboard_done_empty", 32'(done_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
